// File: rtl/boot_rom_copier_pkg.sv
// Shared definitions for the boot ROM to SRAM copier: address widths,
// state encoding and the SRAM address helper.
package boot_rom_copier_pkg;

    localparam int ROM_AW  = 13;
    localparam int SRAM_AW = 21;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // SRAM byte address for a given ROM offset; the sum wraps at 2^21.
    function automatic logic [SRAM_AW-1:0] sram_addr(input logic [SRAM_AW-1:0] base,
                                                     input logic [ROM_AW-1:0]  offs);
        return base + {{(SRAM_AW-ROM_AW){1'b0}}, offs};
    endfunction

endpackage

// File: rtl/boot_rom_copier.sv
// Boot sequencer: after a start pulse it copies every byte of the boot ROM
// into external SRAM, keeps a running 8-bit checksum, and releases the CPU
// from reset once the last byte has been accepted by the SRAM port.
//
// SRAM handshake: sram_req is raised with sram_a/sram_din already stable and
// stays high, with address and data frozen, until a cycle in which sram_ack
// is also high; that cycle is the transfer. sram_ack is meaningless while
// sram_req is low.
module boot_rom_copier
    import boot_rom_copier_pkg::*;
#(
    parameter int          ROM_WORDS = 8192,
    parameter logic [20:0] SRAM_BASE = 21'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [13:0] rom_a,
    input  logic [7:0]  rom_dout,
    output logic [20:0] sram_a,
    output logic [7:0]  sram_din,
    output logic        sram_req,
    input  logic        sram_ack,
    output logic        busy,
    output logic        done,
    output logic        cpu_hold,
    output logic [7:0]  checksum
);

    // Termination is by compare against the last offset; the counter itself never wraps.
    localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(ROM_WORDS - 1);

    state_t               state_q,    state_d;
    logic [ROM_AW-1:0]    addr_q,     addr_d;
    logic [7:0]           data_q,     data_d;
    logic [7:0]           checksum_q, checksum_d;
    logic [13:0]          rom_a_q,    rom_a_d;
    logic [SRAM_AW-1:0]   sram_a_q,   sram_a_d;
    logic                 sram_req_q, sram_req_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic                 cpu_hold_q, cpu_hold_d;

    // Next-state, datapath updates, and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        checksum_d = checksum_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = '0;
                    checksum_d = '0;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                // ROM data for the address presented in FETCH is valid now.
                data_d     = rom_dout;
                checksum_d = checksum_q + rom_dout;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                if (sram_ack) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ROM_AW'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered versions of what the next state implies,
        // so nothing at the ports depends combinationally on an input.
        rom_a_d    = {1'b0, addr_d};
        sram_a_d   = sram_addr(SRAM_BASE, addr_d);
        sram_req_d = (state_d == ST_WRITE);
        busy_d     = (state_d == ST_FETCH) || (state_d == ST_LATCH) || (state_d == ST_WRITE);
        done_d     = (state_d == ST_DONE);
        cpu_hold_d = (state_d != ST_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            rom_a_q    <= '0;
            sram_a_q   <= SRAM_BASE;
            sram_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            checksum_q <= checksum_d;
            rom_a_q    <= rom_a_d;
            sram_a_q   <= sram_a_d;
            sram_req_q <= sram_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign rom_a    = rom_a_q;
    assign sram_a   = sram_a_q;
    assign sram_din = data_q;
    assign sram_req = sram_req_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cpu_hold = cpu_hold_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_boot_rom_copier.sv
// Bench for boot_rom_copier: three instances (4 bytes at a wrapping SRAM
// base, a full 8 KB ROM, and a single byte) driven from one sequence, with a
// cycle-offset reference model and a handful of literal expectations.
module tb_boot_rom_copier;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [NI];
    logic        start    [NI];
    logic [13:0] rom_a    [NI];
    logic [7:0]  rom_dout [NI];
    logic [20:0] sram_a   [NI];
    logic [7:0]  sram_din [NI];
    logic        sram_req [NI];
    logic        sram_ack [NI];
    logic        busy     [NI];
    logic        done     [NI];
    logic        cpu_hold [NI];
    logic [7:0]  checksum [NI];

    boot_rom_copier #(.ROM_WORDS(4), .SRAM_BASE(21'h1FFFFE)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .rom_a(rom_a[0]), .rom_dout(rom_dout[0]),
        .sram_a(sram_a[0]), .sram_din(sram_din[0]), .sram_req(sram_req[0]), .sram_ack(sram_ack[0]),
        .busy(busy[0]), .done(done[0]), .cpu_hold(cpu_hold[0]), .checksum(checksum[0]));

    boot_rom_copier #(.ROM_WORDS(8192), .SRAM_BASE(21'h1FF000)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .rom_a(rom_a[1]), .rom_dout(rom_dout[1]),
        .sram_a(sram_a[1]), .sram_din(sram_din[1]), .sram_req(sram_req[1]), .sram_ack(sram_ack[1]),
        .busy(busy[1]), .done(done[1]), .cpu_hold(cpu_hold[1]), .checksum(checksum[1]));

    boot_rom_copier #(.ROM_WORDS(1), .SRAM_BASE(21'h000010)) u_dut2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .rom_a(rom_a[2]), .rom_dout(rom_dout[2]),
        .sram_a(sram_a[2]), .sram_din(sram_din[2]), .sram_req(sram_req[2]), .sram_ack(sram_ack[2]),
        .busy(busy[2]), .done(done[2]), .cpu_hold(cpu_hold[2]), .checksum(checksum[2]));

    function automatic int words_of(input int k);
        case (k)
            0:       return 4;
            1:       return 8192;
            default: return 1;
        endcase
    endfunction

    function automatic logic [20:0] base_of(input int k);
        case (k)
            0:       return 21'h1FFFFE;
            1:       return 21'h1FF000;
            default: return 21'h000010;
        endcase
    endfunction

    // Registered ROMs: data appears the cycle after the address.
    logic [7:0] rom_mem [NI][8192];
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) rom_dout[k] <= rom_mem[k][rom_a[k][12:0]];
    end

    // Counters and model state.
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit         m_valid  [NI];
    bit         m_rstv   [NI];
    bit         m_active [NI];
    bit         m_done   [NI];
    int         m_idx    [NI];
    int         m_t      [NI];   // cycles elapsed since the current byte started
    logic [7:0] m_sum    [NI];
    int         hs_cnt   [NI];
    int         hs_base  [NI];
    int         ack_mode [NI];
    int         stall_left [NI];
    logic       prev_busy [NI];
    logic       prev_done [NI];
    int         fetch_cyc [NI];
    int         done_cyc  [NI];

    int          focus = 0;
    logic [20:0] log_a [$];
    logic [7:0]  log_d [$];

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // Compare every instance's outputs against the model (run at negedge).
    task automatic compare_all();
        logic exp_req;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (m_valid[k]) begin
                exp_req = m_active[k] && (m_t[k] >= 2);
                check("busy",     k, busy[k],     m_active[k]);
                check("done",     k, done[k],     m_done[k]);
                check("cpu_hold", k, cpu_hold[k], !m_done[k]);
                check("checksum", k, checksum[k], m_sum[k]);
                check("sram_req", k, sram_req[k], exp_req);
                check("rom_a13",  k, rom_a[k][13], 1'b0);
                if (m_rstv[k]) begin
                    check("rst_rom_a",    k, rom_a[k],    14'd0);
                    check("rst_sram_a",   k, sram_a[k],   base_of(k));
                    check("rst_sram_din", k, sram_din[k], 8'd0);
                end
                if (exp_req) begin
                    check("sram_a",   k, sram_a[k],   21'(base_of(k) + 21'(m_idx[k])));
                    check("sram_din", k, sram_din[k], rom_mem[k][m_idx[k]]);
                end
                if (m_active[k] && m_t[k] == 0) check("rom_a", k, rom_a[k], 14'(m_idx[k]));
                if (busy[k] && !prev_busy[k]) fetch_cyc[k] = cyc;
                if (done[k] && !prev_done[k]) done_cyc[k] = cyc;
                prev_busy[k] = busy[k];
                prev_done[k] = done[k];
            end
        end
    endtask

    // Advance the model to what the upcoming clock edge must produce.
    task automatic advance_model();
        for (int k = 0; k < NI; k++) begin
            m_rstv[k] = 1'b0;
            if (rst[k]) begin
                m_valid[k]  = 1'b1;
                m_rstv[k]   = 1'b1;
                m_active[k] = 1'b0;
                m_done[k]   = 1'b0;
                m_idx[k]    = 0;
                m_t[k]      = 0;
                m_sum[k]    = 8'd0;
            end else if (m_valid[k]) begin
                if (m_active[k]) begin
                    if (m_t[k] < 2) begin
                        if (m_t[k] == 1) m_sum[k] = m_sum[k] + rom_mem[k][m_idx[k]];
                        m_t[k] = m_t[k] + 1;
                    end else if (sram_ack[k]) begin
                        if (k == focus) begin
                            log_a.push_back(sram_a[k]);
                            log_d.push_back(sram_din[k]);
                        end
                        hs_cnt[k] = hs_cnt[k] + 1;
                        if (m_idx[k] == words_of(k) - 1) begin
                            m_active[k] = 1'b0;
                            m_done[k]   = 1'b1;
                        end else begin
                            m_idx[k] = m_idx[k] + 1;
                            m_t[k]   = 0;
                        end
                    end
                end else if (!m_done[k] && start[k]) begin
                    m_active[k] = 1'b1;
                    m_idx[k]    = 0;
                    m_t[k]      = 0;
                    m_sum[k]    = 8'd0;
                end
            end
        end
    endtask

    task automatic drive_acks();
        for (int k = 0; k < NI; k++) begin
            case (ack_mode[k])
                0: sram_ack[k] = 1'b1;
                1: sram_ack[k] = ($urandom_range(0, 3) != 0);
                2: begin
                    if ((hs_cnt[k] - hs_base[k]) == 2 && sram_req[k] && stall_left[k] > 0) begin
                        sram_ack[k]   = 1'b0;
                        stall_left[k] = stall_left[k] - 1;
                    end else begin
                        sram_ack[k] = 1'b1;
                    end
                end
                default: sram_ack[k] = ($urandom_range(0, 7) != 0);
            endcase
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        advance_model();
        @(posedge clk);
        #1;
        drive_acks();
    endtask

    task automatic reset_inst(input int k);
        rst[k] = 1'b1;
        cycle();
        rst[k] = 1'b0;
        cycle();
    endtask

    task automatic begin_copy(input int k, input int mode);
        ack_mode[k] = mode;
        hs_base[k]  = hs_cnt[k];
        focus       = k;
        log_a.delete();
        log_d.delete();
        start[k] = 1'b1;
        cycle();
        start[k] = 1'b0;
    endtask

    task automatic run_until_done(input int k, input int budget, input bit noise);
        int n = 0;
        while (!done[k] && n < budget) begin
            start[k] = noise ? ($urandom_range(0, 15) == 0) : 1'b0;
            cycle();
            n++;
        end
        start[k] = 1'b0;
        check("done_reached", k, done[k], 1'b1);
        cycle();
    endtask

    logic [7:0] sum_lit;
    int         n_wait;

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; sram_ack[k] = 1'b0;
            m_valid[k] = 1'b0; m_rstv[k] = 1'b0; m_active[k] = 1'b0; m_done[k] = 1'b0;
            m_idx[k] = 0; m_t[k] = 0; m_sum[k] = 8'd0;
            hs_cnt[k] = 0; hs_base[k] = 0; ack_mode[k] = 0; stall_left[k] = 0;
            prev_busy[k] = 1'b0; prev_done[k] = 1'b0; fetch_cyc[k] = 0; done_cyc[k] = 0;
            for (int a = 0; a < 8192; a++) rom_mem[k][a] = 8'h00;
        end
        repeat (3) cycle();
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        cycle();

        // Basic copy of {01,02,03,04} with ack tied high, wrapping SRAM base.
        for (int a = 0; a < 4; a++) rom_mem[0][a] = 8'(a + 1);
        begin_copy(0, 0);
        run_until_done(0, 200, 1'b0);
        check("lit_nwrites", 0, log_a.size(), 4);
        check("lit_a0", 0, log_a[0], 21'h1FFFFE);
        check("lit_a1", 0, log_a[1], 21'h1FFFFF);
        check("lit_a2", 0, log_a[2], 21'h000000);
        check("lit_a3", 0, log_a[3], 21'h000001);
        for (int i = 0; i < 4; i++) check("lit_data", 0, log_d[i], 8'(i + 1));
        check("lit_checksum", 0, checksum[0], 8'h0A);
        check("lit_latency", 0, done_cyc[0] - fetch_cyc[0], 12);
        check("lit_cpu_hold", 0, cpu_hold[0], 1'b0);

        // Start pulses while in DONE are ignored.
        repeat (3) begin
            start[0] = 1'b1; cycle(); start[0] = 1'b0; cycle();
        end
        check("lit_done_nowrite", 0, log_a.size(), 4);
        check("lit_done_sticky", 0, done[0], 1'b1);

        // Five-cycle ack stall on byte 2.
        reset_inst(0);
        stall_left[0] = 5;
        begin_copy(0, 2);
        run_until_done(0, 200, 1'b0);
        check("lit_stall_latency", 0, done_cyc[0] - fetch_cyc[0], 17);
        check("lit_stall_nwrites", 0, log_a.size(), 4);
        check("lit_stall_checksum", 0, checksum[0], 8'h0A);

        // Start pulsed while a write is pending.
        reset_inst(0);
        begin_copy(0, 0);
        n_wait = 0;
        while (!sram_req[0] && n_wait < 20) begin cycle(); n_wait++; end
        check("wait_req", 0, sram_req[0], 1'b1);
        start[0] = 1'b1; cycle(); start[0] = 1'b0;
        run_until_done(0, 200, 1'b0);
        check("lit_restart_nwrites", 0, log_a.size(), 4);
        check("lit_restart_latency", 0, done_cyc[0] - fetch_cyc[0], 12);

        // Reset while byte 1 is being written, then a fresh copy.
        reset_inst(0);
        sum_lit = 8'd0;
        for (int a = 0; a < 4; a++) begin
            rom_mem[0][a] = 8'($urandom_range(0, 255));
            sum_lit = sum_lit + rom_mem[0][a];
        end
        begin_copy(0, 0);
        n_wait = 0;
        while (!((hs_cnt[0] - hs_base[0]) == 1 && sram_req[0]) && n_wait < 50) begin cycle(); n_wait++; end
        check("wait_byte1", 0, sram_req[0], 1'b1);
        rst[0] = 1'b1;
        cycle();
        rst[0] = 1'b0;
        check("lit_abort_req", 0, sram_req[0], 1'b0);
        check("lit_abort_busy", 0, busy[0], 1'b0);
        check("lit_abort_sum", 0, checksum[0], 8'h00);
        check("lit_abort_hold", 0, cpu_hold[0], 1'b1);
        cycle();
        begin_copy(0, 0);
        run_until_done(0, 200, 1'b0);
        check("lit_recopy_a0", 0, log_a[0], 21'h1FFFFE);
        check("lit_recopy_d0", 0, log_d[0], rom_mem[0][0]);
        check("lit_recopy_sum", 0, checksum[0], sum_lit);

        // Randomized contents, random ack, stray start pulses.
        for (int r = 0; r < 6; r++) begin
            reset_inst(0);
            sum_lit = 8'd0;
            for (int a = 0; a < 4; a++) begin
                rom_mem[0][a] = 8'($urandom_range(0, 255));
                sum_lit = sum_lit + rom_mem[0][a];
            end
            begin_copy(0, 1);
            run_until_done(0, 400, 1'b1);
            check("rand_sum", 0, checksum[0], sum_lit);
        end

        // Single-byte ROM.
        for (int r = 0; r < 3; r++) begin
            reset_inst(2);
            rom_mem[2][0] = 8'($urandom_range(0, 255));
            begin_copy(2, 1);
            run_until_done(2, 200, 1'b1);
            check("one_nwrites", 2, log_a.size(), 1);
            check("one_addr", 2, log_a[0], 21'h000010);
            check("one_data", 2, log_d[0], rom_mem[2][0]);
            check("one_sum", 2, checksum[2], rom_mem[2][0]);
        end

        // Full 8 KB of FF.
        for (int a = 0; a < 8192; a++) rom_mem[1][a] = 8'hFF;
        begin_copy(1, 3);
        run_until_done(1, 60000, 1'b0);
        check("full_nwrites", 1, log_a.size(), 8192);
        check("full_first_a", 1, log_a[0], 21'h1FF000);
        check("full_last_a", 1, log_a[log_a.size() - 1], 21'h000FFF);
        check("full_sum", 1, checksum[1], 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
